mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Bus master for the multi-cycle core, directly downstream of the stage counter.
//  Consumes start_fetch/start_memory pulses and runs one req/ack transaction on the shared memory bus.
//  Drives 'blocked' back to the stage counter until the transaction completes, then presents the
//  fetched instruction or sign/zero-extended load data to the decode/writeback logic.
// PARAMETERS
//  ADDR_WIDTH      32  byte address width of pc, mem_addr, bus_addr
//  TIMEOUT_CYCLES  15  wait-cycle limit before abort (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk             in   1           single core clock, rising edge
//  rst             in   1           asynchronous, active-low reset
//  start_fetch     in   1           1-cycle pulse from stage counter: fetch at pc
//  start_memory    in   1           1-cycle pulse from stage counter: run load/store if mem_re|mem_we
//  pc              in   ADDR_WIDTH  instruction address, word aligned
//  mem_addr        in   ADDR_WIDTH  load/store byte address
//  mem_re/mem_we   in   1/1         load / store request (never both)
//  mem_funct3      in   3           RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  mem_wdata       in   32          store data, right-aligned
//  blocked         out  1           hold the stage counter
//  bus_req         out  1           registered bus request
//  bus_we          out  1           1 = write cycle
//  bus_addr        out  ADDR_WIDTH  word-aligned address (addr[1:0]=0)
//  bus_be          out  4           byte enables
//  bus_wdata       out  32          store data shifted to byte lane
//  bus_ack         in   1           slave completion, sampled while bus_req=1
//  bus_rdata       in   32          read data, valid with bus_ack
//  instr           out  32          last fetched instruction, held until next fetch ack
//  load_data       out  32          last load result, extended per funct3
//  misaligned      out  1           1-cycle pulse: unaligned H/W access rejected
//  bus_error       out  1           1-cycle pulse: transaction aborted by timeout
// BEHAVIOUR
//  - States: IDLE, FETCH, MEM (2-bit). Reset: state IDLE; bus_req, bus_we, bus_be, bus_addr,
//    bus_wdata, instr, load_data, misaligned, bus_error all 0; pending_mem 0.
//  - start_fetch in IDLE: FETCH next edge; bus_req=1, bus_we=0, bus_be=4'hF, bus_addr=pc.
//  - start_memory in IDLE with mem_re|mem_we and aligned address: MEM next edge. bus_addr = mem_addr & ~3.
//    Byte ops: be = 1<<addr[1:0]. Half ops: be = 4'b0011<<addr[1:0].
//    Stores replicate mem_wdata into the active lanes.
//  - start_memory with mem_re=mem_we=0: no bus cycle, blocked stays 0.
//  - Misaligned (H with addr[0]=1, W with addr[1:0]!=0): no bus cycle; misaligned=1 next cycle; blocked 0.
//  - blocked = (state!=IDLE) | pending_mem | start_fetch | (start_memory & (mem_re|mem_we) & aligned).
//    This is combinational, so the counter is held in the same cycle as the start pulse.
//  - Completion: first edge with bus_req & bus_ack. That edge captures data, drops bus_req and returns to IDLE.
//    Minimum blocked span is 2 cycles (ack in the first bus_req cycle).
//  - Load extraction: select lane by addr[1:0]. B/H sign-extend, BU/HU zero-extend, W passes through.
//  - start_fetch and start_memory in the same cycle: fetch first. pending_mem latches the memory request
//    (addr, funct3, wdata, re/we). MEM begins the edge after the fetch ack. blocked stays 1 throughout.
//  - Start pulses while state!=IDLE are ignored.
//  - bus_ack while bus_req=0 is ignored.
//  - rst low at any time: immediate return to reset values, including mid-transaction.
//    bus_req drops asynchronously; pending request discarded.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined:
//    - 4-bit wait counter clears on entry to FETCH/MEM and increments each cycle without ack.
//    - When the counter reaches TIMEOUT_CYCLES with no ack: bus_req drops, state returns to IDLE,
//      bus_error pulses 1 cycle, and instr/load_data are unchanged.
//    - A pending memory request is discarded on timeout.
//  MEM_TIMEOUT_EN undefined: waits indefinitely; bus_error tied 0; no counter logic.
// TESTING
//  1. rst=0 then 1 at 20ns -> all outputs 0. start_fetch, pc=0x100, ack 3 cycles later with rdata=0x00500093
//     -> bus_addr=0x100, be=F, blocked 5 cycles, instr=0x00500093.
//  2. LB addr=0x203, rdata=0x80xxxxxx -> be=1000, load_data=0xFFFFFF80. Same with LBU -> load_data=0x00000080.
//  3. SH addr=0x302, wdata=0x1234ABCD -> bus_we=1, be=1100, bus_wdata[31:16]=0xABCD, bus_addr=0x300.
//  4. LW addr=0x401 -> no bus_req, misaligned pulse, blocked=0. start_fetch+start_memory together
//     -> fetch completes, then MEM; blocked continuous.
//  5. Assert rst low while bus_req=1 -> bus_req=0 asynchronously, state IDLE. A later ack is ignored.
//  6. MEM_TIMEOUT_EN, no ack -> bus_req drops after 15 wait cycles, bus_error pulses once, blocked returns to 0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Req/ack bus master for instruction fetch and load/store; holds the stage counter via 'blocked'.
// Define MEM_TIMEOUT_EN to abort transactions that see no ack within TIMEOUT_CYCLES wait cycles.
module mem_access_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_fetch,
    input  logic                  start_memory,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_re,
    input  logic                  mem_we,
    input  logic [2:0]            mem_funct3,
    input  logic [31:0]           mem_wdata,
    output logic                  blocked,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [3:0]            bus_be,
    output logic [31:0]           bus_wdata,
    input  logic                  bus_ack,
    input  logic [31:0]           bus_rdata,
    output logic [31:0]           instr,
    output logic [31:0]           load_data,
    output logic                  misaligned,
    output logic                  bus_error
);

    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, MEM = 2'd2} state_t;

    state_t                state_q, state_d;
    logic                  bus_req_q, bus_req_d;
    logic                  bus_we_q, bus_we_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]            bus_be_q, bus_be_d;
    logic [31:0]           bus_wdata_q, bus_wdata_d;
    logic [31:0]           instr_q, instr_d;
    logic [31:0]           load_data_q, load_data_d;
    logic                  misaligned_q, misaligned_d;
    logic [2:0]            op_f3_q, op_f3_d;
    logic [1:0]            op_off_q, op_off_d;
    logic                  pending_q, pending_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic [2:0]            pend_f3_q, pend_f3_d;
    logic [31:0]           pend_wdata_q, pend_wdata_d;
    logic                  pend_we_q, pend_we_d;

    logic [ADDR_WIDTH-1:0] req_addr;
    logic [2:0]            req_f3;
    logic [31:0]           req_wdata, req_lanes, lane, load_ext;
    logic                  req_we, req_aligned, mem_valid, mem_go;
    logic [3:0]            req_be;

`ifdef MEM_TIMEOUT_EN
    localparam logic [3:0] WAIT_LIMIT = 4'(TIMEOUT_CYCLES - 1);
    logic [3:0] wait_q, wait_d;
    logic       bus_error_q, bus_error_d;
`endif

    // A latched request waiting behind a fetch takes the place of the live inputs.
    assign req_addr  = pending_q ? pend_addr_q  : mem_addr;
    assign req_f3    = pending_q ? pend_f3_q    : mem_funct3;
    assign req_wdata = pending_q ? pend_wdata_q : mem_wdata;
    assign req_we    = pending_q ? pend_we_q    : mem_we;
    assign mem_valid = mem_re | mem_we;

    always_comb begin
        req_aligned = 1'b1;
        req_be      = 4'hF;
        req_lanes   = req_wdata;
        case (req_f3[1:0])
            2'b00: begin
                req_be    = 4'b0001 << req_addr[1:0];
                req_lanes = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_aligned = ~req_addr[0];
                req_be      = 4'b0011 << req_addr[1:0];
                req_lanes   = {2{req_wdata[15:0]}};
            end
            default: req_aligned = (req_addr[1:0] == 2'b00);
        endcase
    end

    always_comb begin
        lane     = bus_rdata >> {op_off_q, 3'b000};
        load_ext = lane;
        case (op_f3_q)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {24'b0, lane[7:0]};
            3'b101:  load_ext = {16'b0, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    assign blocked = (state_q != IDLE) | pending_q | start_fetch
                   | (start_memory & mem_valid & req_aligned);
    assign mem_go  = pending_q | (start_memory & mem_valid & req_aligned & ~start_fetch);

    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        instr_d      = instr_q;
        load_data_d  = load_data_q;
        misaligned_d = 1'b0;
        op_f3_d      = op_f3_q;
        op_off_d     = op_off_q;
        pending_d    = pending_q;
        pend_addr_d  = pend_addr_q;
        pend_f3_d    = pend_f3_q;
        pend_wdata_d = pend_wdata_q;
        pend_we_d    = pend_we_q;
`ifdef MEM_TIMEOUT_EN
        wait_d      = wait_q;
        bus_error_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (mem_go) begin
                    state_d     = MEM;
                    bus_req_d   = 1'b1;
                    bus_we_d    = req_we;
                    bus_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                    bus_be_d    = req_be;
                    bus_wdata_d = req_lanes;
                    op_f3_d     = req_f3;
                    op_off_d    = req_addr[1:0];
                    pending_d   = 1'b0;
`ifdef MEM_TIMEOUT_EN
                    wait_d = 4'd0;
`endif
                end else if (start_fetch) begin
                    state_d      = FETCH;
                    bus_req_d    = 1'b1;
                    bus_we_d     = 1'b0;
                    bus_addr_d   = {pc[ADDR_WIDTH-1:2], 2'b00};
                    bus_be_d     = 4'hF;
                    pending_d    = start_memory & mem_valid & req_aligned;
                    pend_addr_d  = mem_addr;
                    pend_f3_d    = mem_funct3;
                    pend_wdata_d = mem_wdata;
                    pend_we_d    = mem_we;
`ifdef MEM_TIMEOUT_EN
                    wait_d = 4'd0;
`endif
                end
                if (!pending_q && start_memory && mem_valid && !req_aligned) begin
                    misaligned_d = 1'b1;
                end
            end
            FETCH, MEM: begin
                if (bus_ack) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    if (state_q == FETCH) begin
                        instr_d = bus_rdata;
                    end else if (!bus_we_q) begin
                        load_data_d = load_ext;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (wait_q == WAIT_LIMIT) begin
                    state_d     = IDLE;
                    bus_req_d   = 1'b0;
                    bus_error_d = 1'b1;
                    pending_d   = 1'b0;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= 4'h0;
            bus_wdata_q  <= 32'h0;
            instr_q      <= 32'h0;
            load_data_q  <= 32'h0;
            misaligned_q <= 1'b0;
            op_f3_q      <= 3'b0;
            op_off_q     <= 2'b0;
            pending_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_f3_q    <= 3'b0;
            pend_wdata_q <= 32'h0;
            pend_we_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_q      <= 4'd0;
            bus_error_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
            instr_q      <= instr_d;
            load_data_q  <= load_data_d;
            misaligned_q <= misaligned_d;
            op_f3_q      <= op_f3_d;
            op_off_q     <= op_off_d;
            pending_q    <= pending_d;
            pend_addr_q  <= pend_addr_d;
            pend_f3_q    <= pend_f3_d;
            pend_wdata_q <= pend_wdata_d;
            pend_we_q    <= pend_we_d;
`ifdef MEM_TIMEOUT_EN
            wait_q      <= wait_d;
            bus_error_q <= bus_error_d;
`endif
        end
    end

    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;
    assign instr      = instr_q;
    assign load_data  = load_data_q;
    assign misaligned = misaligned_q;
`ifdef MEM_TIMEOUT_EN
    assign bus_error  = bus_error_q;
`else
    assign bus_error  = 1'b0;
`endif

endmodule
